simon_sequencer: RTL and testbench

Parametrised successor to the Simon game controller. It merges the mode FSM with its own sequence-length counter, read pointer, legality check and compare logic. It drives an external pattern memory through write and read ports, and advances only on qualified `step` pulses. Width, depth and a win/lose outcome are configurable and observable.

---
 rtl/simon_pkg.sv | 30 +++
 rtl/simon_ptr.sv | 54 +++++
 rtl/simon_sequencer.sv | 150 +++++++++++++++
 tb/tb_simon_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg
//   Shared definitions for the Simon sequencer: controller states and the
//   mode-indicator encodings driven onto mode_leds.
package simon_pkg;

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } simon_state_e;

  localparam logic [2:0] MODE_INPUT    = 3'b001;
  localparam logic [2:0] MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] MODE_REPEAT   = 3'b100;
  localparam logic [2:0] MODE_DONE     = 3'b111;

  function automatic logic [2:0] mode_of(simon_state_e s);
    logic [2:0] m;
    unique case (s)
      ST_INPUT:    m = MODE_INPUT;
      ST_PLAYBACK: m = MODE_PLAYBACK;
      ST_REPEAT:   m = MODE_REPEAT;
      ST_DONE:     m = MODE_DONE;
      default:     m = MODE_INPUT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/simon_ptr.sv
// simon_ptr
//   AW-bit pointer with synchronous clear, enable and wrap-at-limit.
//   On an enabled edge the pointer increments, or returns to 0 when it
//   already sits on limit-1. Clear takes priority over enable.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   clr_i        force pointer to 0 on next edge
//   en_i         advance (with wrap) on next edge
//   limit_i      AW+1-bit length; the wrap point is limit_i-1
//   ptr_o        current pointer
//   at_last_o    pointer equals limit_i-1 (compared at AW+1 bits)
module simon_ptr
  import simon_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [AW:0]   limit_i,
  output logic [AW-1:0] ptr_o,
  output logic          at_last_o
);

  localparam logic [AW:0]   LIM_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] ptr_q, ptr_d;

  // With limit 0 the subtraction yields all-ones, which the zero-extended
  // pointer can never equal, so an empty sequence never reports "last".
  assign at_last_o = ({1'b0, ptr_q} == (limit_i - LIM_ONE));

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = at_last_o ? '0 : (ptr_q + PTR_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer
//   Simon game controller: records one player entry per round into an
//   external pattern memory, plays the stored sequence back, checks the
//   player's repeat against it and ends in DONE with a win/lose flag.
//   Everything advances only on clock edges where step is high.
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   step       advance qualifier (debounced button pulse)
//   pattern    player switches (legal = exactly one bit set)
//   wr_en      pattern-memory write strobe
//   wr_addr    write address (current sequence length)
//   wr_data    write data (the player's pattern)
//   rd_addr    read address (replay / compare pointer)
//   rd_data    memory read data, combinational from rd_addr
//   leds       game LEDs: pattern in INPUT/REPEAT, rd_data otherwise
//   mode_leds  mode indicator 001/010/100/111
//   seq_len    number of stored entries
//   win        in DONE: player completed a full-DEPTH sequence
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [WIDTH-1:0] pattern,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] leds,
  output logic [2:0]       mode_leds,
  output logic [AW:0]      seq_len,
  output logic             win
);

  localparam logic [AW:0]      SEQ_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      SEQ_FULL = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] PAT_ONE  = WIDTH'(1);

  simon_state_e  state_q, state_d;
  logic [AW:0]   seq_len_q, seq_len_d;
  logic          win_q, win_d;

  logic          ptr_clr;
  logic          ptr_en;
  logic [AW-1:0] ptr;
  logic          at_last;

  logic          legal;
  logic          match;

  // One-hot test: nonzero and clearing the lowest set bit leaves nothing.
  assign legal = (pattern != '0) && ((pattern & (pattern - PAT_ONE)) == '0);
  assign match = (pattern == rd_data);

  simon_ptr #(
    .AW (AW)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (ptr_clr),
    .en_i      (ptr_en),
    .limit_i   (seq_len_q),
    .ptr_o     (ptr),
    .at_last_o (at_last)
  );

  // Where the pointer must return to 0 after its last entry (end of
  // playback, final correct repeat, DONE replay) the pointer's own wrap
  // does it; an explicit clear is only needed when leaving from the middle.
  always_comb begin
    state_d   = state_q;
    seq_len_d = seq_len_q;
    win_d     = win_q;
    ptr_clr   = 1'b0;
    ptr_en    = 1'b0;
    if (step) begin
      unique case (state_q)
        ST_INPUT: begin
          if (legal) begin
            seq_len_d = seq_len_q + SEQ_ONE;
            ptr_clr   = 1'b1;
            state_d   = ST_PLAYBACK;
          end
        end
        ST_PLAYBACK: begin
          ptr_en = 1'b1;
          if (at_last) begin
            state_d = ST_REPEAT;
          end
        end
        ST_REPEAT: begin
          if (legal) begin
            if (match) begin
              ptr_en = 1'b1;
              if (at_last) begin
                if (seq_len_q == SEQ_FULL) begin
                  win_d   = 1'b1;
                  state_d = ST_DONE;
                end else begin
                  state_d = ST_INPUT;
                end
              end
            end else begin
              ptr_clr = 1'b1;
              win_d   = 1'b0;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          ptr_en = 1'b1;
        end
        default: begin
          state_d = ST_INPUT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INPUT;
      seq_len_q <= '0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_len_q <= seq_len_d;
      win_q     <= win_d;
    end
  end

  // Write strobe is held off while reset is asserted so a held step during
  // reset cannot scribble on the memory.
  assign wr_en     = rst && (state_q == ST_INPUT) && step && legal;
  assign wr_addr   = seq_len_q[AW-1:0];
  assign wr_data   = pattern;
  assign rd_addr   = ptr;
  assign leds      = ((state_q == ST_INPUT) || (state_q == ST_REPEAT)) ? pattern : rd_data;
  assign mode_leds = mode_of(state_q);
  assign seq_len   = seq_len_q;
  assign win       = win_q;

endmodule

// File: tb/tb_simon_sequencer.sv
module tb_simon_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  localparam int M_INPUT    = 0;
  localparam int M_PLAYBACK = 1;
  localparam int M_REPEAT   = 2;
  localparam int M_DONE     = 3;

  logic             clk;
  logic             rst;
  logic             step;
  logic [WIDTH-1:0] pattern;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] leds;
  logic [2:0]       mode_leds;
  logic [AW:0]      seq_len;
  logic             win;

  logic [WIDTH-1:0] mem [DEPTH];

  int n_vec;
  int n_err;

  // Reference model: game mode, the recorded sequence, the position in it.
  int               m_mode;
  logic [WIDTH-1:0] m_seq [$];
  int               m_idx;
  bit               m_win;

  simon_sequencer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .pattern   (pattern),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .leds      (leds),
    .mode_leds (mode_leds),
    .seq_len   (seq_len),
    .win       (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-latency external pattern memory.
  assign rd_data = mem[rd_addr];
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  function automatic bit is_legal(input logic [WIDTH-1:0] p);
    return $countones(p) == 1;
  endfunction

  function automatic logic [2:0] exp_mode_leds();
    case (m_mode)
      M_INPUT:    return 3'b001;
      M_PLAYBACK: return 3'b010;
      M_REPEAT:   return 3'b100;
      default:    return 3'b111;
    endcase
  endfunction

  function automatic void model_reset();
    m_mode = M_INPUT;
    m_seq.delete();
    m_idx  = 0;
    m_win  = 1'b0;
  endfunction

  function automatic void model_step(input bit st, input logic [WIDTH-1:0] p);
    int last;
    if (!st) return;
    last = m_seq.size() - 1;
    case (m_mode)
      M_INPUT: begin
        if (is_legal(p)) begin
          m_seq.push_back(p);
          m_idx  = 0;
          m_mode = M_PLAYBACK;
        end
      end
      M_PLAYBACK: begin
        if (m_idx == last) begin
          m_idx  = 0;
          m_mode = M_REPEAT;
        end else begin
          m_idx++;
        end
      end
      M_REPEAT: begin
        if (is_legal(p)) begin
          if (p == m_seq[m_idx]) begin
            if (m_idx == last) begin
              m_idx = 0;
              if (m_seq.size() == DEPTH) begin
                m_win  = 1'b1;
                m_mode = M_DONE;
              end else begin
                m_mode = M_INPUT;
              end
            end else begin
              m_idx++;
            end
          end else begin
            m_idx  = 0;
            m_win  = 1'b0;
            m_mode = M_DONE;
          end
        end
      end
      default: begin
        m_idx = (m_idx + 1) % m_seq.size();
      end
    endcase
  endfunction

  // Drives one clock with the given inputs and compares every output with
  // the reference model before and after the edge.
  task automatic run_cycle(input bit st, input logic [WIDTH-1:0] p);
    logic             exp_wr;
    logic [WIDTH-1:0] exp_leds;
    @(negedge clk);
    step    = st;
    pattern = p;
    #1;
    exp_wr   = (m_mode == M_INPUT) && st && is_legal(p);
    exp_leds = ((m_mode == M_INPUT) || (m_mode == M_REPEAT)) ? p : m_seq[m_idx];
    n_vec++;
    if (wr_en !== exp_wr) begin
      n_err++;
      $display("FAIL wr_en: got %b want %b (pattern %b step %b)", wr_en, exp_wr, p, st);
    end
    n_vec++;
    if (wr_addr !== AW'(m_seq.size())) begin
      n_err++;
      $display("FAIL wr_addr: got %0d want %0d", wr_addr, AW'(m_seq.size()));
    end
    n_vec++;
    if (wr_data !== p) begin
      n_err++;
      $display("FAIL wr_data: got %b want %b", wr_data, p);
    end
    n_vec++;
    if (leds !== exp_leds) begin
      n_err++;
      $display("FAIL leds: got %b want %b (mode %0d)", leds, exp_leds, m_mode);
    end
    @(posedge clk);
    model_step(st, p);
    #1;
    n_vec++;
    if (mode_leds !== exp_mode_leds()) begin
      n_err++;
      $display("FAIL mode_leds: got %b want %b", mode_leds, exp_mode_leds());
    end
    n_vec++;
    if (seq_len !== (AW+1)'(m_seq.size())) begin
      n_err++;
      $display("FAIL seq_len: got %0d want %0d", seq_len, m_seq.size());
    end
    n_vec++;
    if (rd_addr !== AW'(m_idx)) begin
      n_err++;
      $display("FAIL rd_addr: got %0d want %0d", rd_addr, m_idx);
    end
    n_vec++;
    if (win !== m_win) begin
      n_err++;
      $display("FAIL win: got %b want %b", win, m_win);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    step = 1'b0;
    rst  = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Enter v, sit through the playback, then repeat the whole sequence.
  task automatic play_round(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] expect_seq [$];
    run_cycle(1'b1, v);
    repeat (m_seq.size()) run_cycle(1'b1, 4'($urandom));
    expect_seq = m_seq;
    foreach (expect_seq[i]) run_cycle(1'b1, expect_seq[i]);
  endtask

  task automatic hold_cycles(input int n);
    repeat (n) run_cycle(1'b0, 4'($urandom));
  endtask

  task automatic test_reset();
    @(negedge clk);
    step    = 1'b1;
    pattern = 4'b0100;
    rst     = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (mode_leds !== 3'b001) begin
      n_err++; $display("FAIL reset_mode: got %b want 001", mode_leds);
    end
    n_vec++;
    if (seq_len !== 3'd0) begin
      n_err++; $display("FAIL reset_seq_len: got %0d want 0", seq_len);
    end
    n_vec++;
    if (rd_addr !== 2'd0) begin
      n_err++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr);
    end
    n_vec++;
    if (win !== 1'b0) begin
      n_err++; $display("FAIL reset_win: got %b want 0", win);
    end
    n_vec++;
    if (wr_en !== 1'b0) begin
      n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en);
    end
    n_vec++;
    if (leds !== 4'b0100) begin
      n_err++; $display("FAIL reset_leds: got %b want 0100", leds);
    end
    @(negedge clk);
    step = 1'b0;
    rst  = 1'b1;
  endtask

  task automatic test_illegal_input();
    logic [WIDTH-1:0] bad [3];
    bad[0] = 4'b0011;
    bad[1] = 4'b0000;
    bad[2] = 4'b1111;
    do_reset();
    foreach (bad[i]) begin
      run_cycle(1'b1, bad[i]);
      n_vec++;
      if (mode_leds !== 3'b001 || seq_len !== 3'd0) begin
        n_err++;
        $display("FAIL illegal_stay: got mode %b len %0d want 001 0", mode_leds, seq_len);
      end
    end
  endtask

  task automatic test_first_entry();
    do_reset();
    run_cycle(1'b1, 4'b0100);
    n_vec++;
    if (mode_leds !== 3'b010 || seq_len !== 3'd1 || leds !== 4'b0100) begin
      n_err++;
      $display("FAIL first_entry: got mode %b len %0d leds %b want 010 1 0100",
               mode_leds, seq_len, leds);
    end
    run_cycle(1'b1, 4'b1001);
    n_vec++;
    if (mode_leds !== 3'b100) begin
      n_err++; $display("FAIL to_repeat: got %b want 100", mode_leds);
    end
    hold_cycles(10);
  endtask

  task automatic test_win();
    do_reset();
    hold_cycles(10);
    play_round(4'b0100);
    n_vec++;
    if (mode_leds !== 3'b001 || seq_len !== 3'd1) begin
      n_err++; $display("FAIL round1_back: got mode %b len %0d want 001 1", mode_leds, seq_len);
    end
    play_round(4'b0001);
    play_round(4'b1000);
    run_cycle(1'b1, 4'b0010);
    hold_cycles(10);
    repeat (4) run_cycle(1'b1, 4'b0000);
    run_cycle(1'b1, 4'b0100);
    run_cycle(1'b1, 4'b0001);
    run_cycle(1'b1, 4'b1000);
    run_cycle(1'b1, 4'b0010);
    n_vec++;
    if (mode_leds !== 3'b111 || win !== 1'b1 || seq_len !== 3'd4) begin
      n_err++;
      $display("FAIL win_done: got mode %b win %b len %0d want 111 1 4", mode_leds, win, seq_len);
    end
    hold_cycles(10);
    repeat (6) run_cycle(1'b1, 4'($urandom));
  endtask

  task automatic test_lose();
    do_reset();
    play_round(4'b0100);
    run_cycle(1'b1, 4'b0001);
    run_cycle(1'b1, 4'b0000);
    run_cycle(1'b1, 4'b0000);
    run_cycle(1'b1, 4'b0100);
    run_cycle(1'b1, 4'b1000);
    n_vec++;
    if (mode_leds !== 3'b111 || win !== 1'b0 || rd_addr !== 2'd0) begin
      n_err++;
      $display("FAIL lose_done: got mode %b win %b ptr %0d want 111 0 0", mode_leds, win, rd_addr);
    end
    run_cycle(1'b1, 4'b0000);
    n_vec++;
    if (rd_addr !== 2'd1) begin
      n_err++; $display("FAIL replay1: got %0d want 1", rd_addr);
    end
    run_cycle(1'b1, 4'b0000);
    n_vec++;
    if (rd_addr !== 2'd0) begin
      n_err++; $display("FAIL replay_wrap: got %0d want 0", rd_addr);
    end
    hold_cycles(10);
  endtask

  task automatic test_reset_midgame();
    do_reset();
    play_round(4'b0100);
    play_round(4'b0001);
    run_cycle(1'b1, 4'b1000);
    run_cycle(1'b1, 4'b0000);
    n_vec++;
    if (mode_leds !== 3'b010 || seq_len !== 3'd3) begin
      n_err++; $display("FAIL mid_setup: got mode %b len %0d want 010 3", mode_leds, seq_len);
    end
    @(negedge clk);
    #3;
    step    = 1'b1;
    pattern = 4'b0100;
    rst     = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (mode_leds !== 3'b001 || seq_len !== 3'd0 || rd_addr !== 2'd0 || wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got mode %b len %0d ptr %0d wr_en %b want 001 0 0 0",
               mode_leds, seq_len, rd_addr, wr_en);
    end
    @(negedge clk);
    step = 1'b0;
    rst  = 1'b1;
    run_cycle(1'b1, 4'b0010);
  endtask

  task automatic test_random_games();
    logic [WIDTH-1:0] p;
    bit               st;
    for (int g = 0; g < 10; g++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        st = ($urandom_range(0, 9) < 8);
        if (m_mode == M_REPEAT && $urandom_range(0, 9) < 8) begin
          p = m_seq[m_idx];
        end else if ($urandom_range(0, 3) == 0) begin
          p = 4'($urandom);
        end else begin
          p = 4'(1 << $urandom_range(0, 3));
        end
        run_cycle(st, p);
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    step    = 1'b0;
    pattern = '0;
    model_reset();
    test_reset();
    test_illegal_input();
    test_first_entry();
    test_win();
    test_lose();
    test_reset_midgame();
    test_random_games();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
